// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server
//   Shares one 16-bit Fibonacci LFSR among NREQ requesters. Requests are
//   served round-robin; each granted requester receives a word that is the
//   LFSR state after STEPS_PER_WORD advances. The generator can be reseeded
//   at any time, which aborts any service in progress.
//
// Ports
//   clk         clock
//   nReset      asynchronous active-low reset
//   seed_load   single-cycle pulse: load seed (zero seed -> DEFAULT_SEED)
//   seed        seed value, sampled when seed_load=1
//   req         per-requester request level, held until gnt
//   gnt         one-hot grant, one cycle wide
//   rnd_data    current LFSR state; the delivered word when rnd_valid=1
//   rnd_valid   high in the grant cycle only
//   busy        FSM not idle
//   word_count  number of words delivered (wraps)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; round-robin pick latched on entry to STEP
// STEP  | advancing the LFSR once per cycle, counting down the steps
// GRANT | presenting gnt/rnd_valid/rnd_data for the latched winner

module lfsr_rr_server #(
    parameter int          NREQ           = 4,
    parameter int          STEPS_PER_WORD = 1,
    parameter logic [15:0] DEFAULT_SEED   = 16'hACE1
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            seed_load,
    input  logic [15:0]     seed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd_data,
    output logic            rnd_valid,
    output logic            busy,
    output logic [15:0]     word_count
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [4:0]      cnt;
    logic [PW-1:0]   pick;
    logic            pick_ok;
    logic [15:0]     lfsr_next;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Scan from the highest offset down so the last hit wins: that is the
    // first set request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                pick    = PW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            lfsr       <= DEFAULT_SEED;
            ptr        <= '0;
            winner     <= '0;
            cnt        <= '0;
            word_count <= '0;
        end else if (seed_load) begin
            lfsr  <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        winner <= pick;
                        cnt    <= 5'(STEPS_PER_WORD);
                        state  <= STEP;
                    end
                end
                STEP: begin
                    lfsr <= lfsr_next;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    word_count <= word_count + 16'd1;
                    ptr        <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reseed arriving in the grant cycle aborts delivery, so the grant
    // strobes are masked by seed_load in that same cycle.
    assign rnd_valid = (state == GRANT) && !seed_load;
    assign gnt       = rnd_valid ? (NREQ'(1) << winner) : '0;
    assign busy      = (state != IDLE);
    assign rnd_data  = lfsr;

endmodule
